imem_access_ctrl: RTL and testbench

Arbitration and sequencing controller for the single-port synchronous instruction memory. It shares the memory between the core fetch port and the program loader (debug/boot link). After reset it holds the core while the loader programs memory, then hands the memory to fetch with a bounded-starvation slot for the loader. It sits between the fetch stage, the loader and the instruction memory array, and it also performs PC range checking: a negative or out-of-range PC yields instruction 0.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_addr_check.sv | 28 ++
 rtl/imem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_imem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and default sizing for the instruction-memory access controller.
package imem_pkg;

    localparam int DEPTH_DEF    = 256;
    localparam int MAX_WAIT_DEF = 8;

    typedef enum logic {
        LOAD,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        FETCH,
        LOADER,
        FETCH_ERR_RSP
    } owner_t;

endpackage

// File: rtl/imem_addr_check.sv
// Range checker: byte-addressed PCs (sign, alignment, depth) or plain word indices (depth only).
module imem_addr_check #(
    parameter int DEPTH     = 256,
    parameter int AW        = 32,
    parameter bit BYTE_ADDR = 1'b1
) (
    input  logic [AW-1:0]              addr,
    output logic                       bad,
    output logic [$clog2(DEPTH)-1:0]   idx
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AW-1:0] DEPTH_V = AW'(DEPTH);

    generate
        if (BYTE_ADDR) begin : g_byte
            logic [AW-1:0] word;
            assign word = {2'b00, addr[AW-1:2]};
            // Bit 31 set is already out of range, but flagged explicitly for negative PCs.
            assign bad  = addr[AW-1] | (addr[1:0] != 2'b00) | (word >= DEPTH_V);
            assign idx  = word[IDX_W-1:0];
        end else begin : g_word
            assign bad = (addr >= DEPTH_V);
            assign idx = addr[IDX_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares the single-port instruction memory between core fetch and the program loader,
// with a LOAD/RUN sequencer, bounded loader starvation and PC range checking.
module imem_access_ctrl
    import imem_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_gnt,
    output logic             fetch_valid,
    output logic [31:0]      fetch_inst,
    output logic             fetch_err,
    input  logic             ld_req,
    input  logic             ld_we,
    input  logic [IDX_W:0]   ld_addr,
    input  logic [31:0]      ld_wdata,
    output logic             ld_gnt,
    output logic             ld_rvalid,
    output logic [31:0]      ld_rdata,
    input  logic             ld_done,
    input  logic             ld_halt,
    output logic             core_hold,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_t           state, state_nxt;
    logic [7:0]       wait_cnt;
    logic             forced;
    logic             fetch_bad, ld_bad;
    logic [IDX_W-1:0] fetch_idx, ld_idx;
    owner_t           fetch_own_p1, ld_own_p1;
    logic             ld_zero_p1;

    imem_addr_check #(.DEPTH(DEPTH), .AW(32), .BYTE_ADDR(1'b1)) u_fetch_chk (
        .addr (fetch_pc),
        .bad  (fetch_bad),
        .idx  (fetch_idx)
    );

    imem_addr_check #(.DEPTH(DEPTH), .AW(IDX_W+1), .BYTE_ADDR(1'b0)) u_ld_chk (
        .addr (ld_addr),
        .bad  (ld_bad),
        .idx  (ld_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (ld_done) state_nxt = RUN;
            RUN:     if (ld_halt) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    assign core_hold = (state == LOAD);
    assign forced    = (state == RUN) && ld_req && (wait_cnt == WAIT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((state_nxt != state) || ld_gnt) begin
            wait_cnt <= '0;
        end else if ((state == RUN) && ld_req && (wait_cnt < WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Arbiter: grants and memory strobes are combinational and forced low in reset.
    always_comb begin
        fetch_gnt = 1'b0;
        ld_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            if (state == LOAD) begin
                ld_gnt = ld_req;
            end else if (fetch_req && !forced) begin
                fetch_gnt = 1'b1;
                ld_gnt    = ld_req && fetch_bad;
            end else begin
                ld_gnt = ld_req;
            end

            if (fetch_gnt && !fetch_bad) begin
                mem_en   = 1'b1;
                mem_addr = fetch_idx;
            end else if (ld_gnt && !ld_bad) begin
                mem_en    = 1'b1;
                mem_we    = ld_we;
                mem_addr  = ld_idx;
                mem_wdata = ld_we ? ld_wdata : '0;
            end
        end
    end

    // Stage p1: owner of the response data returned one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_own_p1 <= NONE;
            ld_own_p1    <= NONE;
        end else begin
            fetch_own_p1 <= !fetch_gnt ? NONE : (fetch_bad ? FETCH_ERR_RSP : FETCH);
            ld_own_p1    <= (ld_gnt && !ld_we) ? LOADER : NONE;
        end
    end

    always_ff @(posedge clk) begin
        ld_zero_p1 <= ld_bad;
    end

    assign fetch_valid = (fetch_own_p1 != NONE);
    assign fetch_err   = (fetch_own_p1 == FETCH_ERR_RSP);
    assign fetch_inst  = (fetch_own_p1 == FETCH) ? mem_rdata : '0;
    assign ld_rvalid   = (ld_own_p1 == LOADER);
    assign ld_rdata    = (ld_rvalid && !ld_zero_p1) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed, table-driven bench for imem_access_ctrl with a behavioural 1-cycle-latency memory.
module tb_imem_access_ctrl;

    localparam int DEPTH = 256;
    localparam int IDX_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fetch_req;
    logic [31:0]      fetch_pc;
    logic             fetch_gnt, fetch_valid, fetch_err;
    logic [31:0]      fetch_inst;
    logic             ld_req, ld_we;
    logic [IDX_W:0]   ld_addr;
    logic [31:0]      ld_wdata;
    logic             ld_gnt, ld_rvalid;
    logic [31:0]      ld_rdata;
    logic             ld_done, ld_halt, core_hold;
    logic             mem_en, mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      mem_wdata, mem_rdata;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] words [0:3];

    int n_checks;
    int n_fail;

    imem_access_ctrl #(.DEPTH(DEPTH), .MAX_WAIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_err(fetch_err),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ld_done(ld_done), .ld_halt(ld_halt), .core_hold(core_hold),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic        fr;
        logic [31:0] pc;
        logic        lr;
        logic [8:0]  la;
        logic        e_fg;
        logic        e_lg;
        logic        e_me;
        logic        e_fv;
        logic [31:0] e_fi;
        logic        e_fe;
        logic        e_lv;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs [0:11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " fetch_gnt"},   32'(fetch_gnt),   32'd0);
        chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, " fetch_inst"},  fetch_inst,       32'd0);
        chk({tag, " fetch_err"},   32'(fetch_err),   32'd0);
        chk({tag, " ld_gnt"},      32'(ld_gnt),      32'd0);
        chk({tag, " ld_rvalid"},   32'(ld_rvalid),   32'd0);
        chk({tag, " ld_rdata"},    ld_rdata,         32'd0);
        chk({tag, " mem_en"},      32'(mem_en),      32'd0);
        chk({tag, " mem_we"},      32'(mem_we),      32'd0);
        chk({tag, " mem_addr"},    32'(mem_addr),    32'd0);
        chk({tag, " mem_wdata"},   mem_wdata,        32'd0);
        chk({tag, " core_hold"},   32'(core_hold),   32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
        mem_rdata = 32'd0;
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        words[2] = 32'h00200113;
        words[3] = 32'h00300193;

        //            fr  pc            lr  la    fg lg me fv fi            fe lv ld
        vecs[0]  = '{1'b1, 32'h0,        1'b0, 9'd0,   1, 0, 1, 1, 32'h00000013, 0, 0, 32'h0};
        vecs[1]  = '{1'b1, 32'h4,        1'b0, 9'd0,   1, 0, 1, 1, 32'h00100093, 0, 0, 32'h0};
        vecs[2]  = '{1'b1, 32'h8,        1'b0, 9'd0,   1, 0, 1, 1, 32'h00200113, 0, 0, 32'h0};
        vecs[3]  = '{1'b1, 32'hFFFFFFFC, 1'b1, 9'd3,   1, 1, 1, 1, 32'h0,        1, 1, 32'h00300193};
        vecs[4]  = '{1'b1, 32'h00000400, 1'b1, 9'd2,   1, 1, 1, 1, 32'h0,        1, 1, 32'h00200113};
        vecs[5]  = '{1'b1, 32'h00000002, 1'b0, 9'd0,   1, 0, 0, 1, 32'h0,        1, 0, 32'h0};
        vecs[6]  = '{1'b1, 32'h80000000, 1'b0, 9'd0,   1, 0, 0, 1, 32'h0,        1, 0, 32'h0};
        vecs[7]  = '{1'b1, 32'h000003FC, 1'b0, 9'd0,   1, 0, 1, 1, 32'h0,        0, 0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,        1'b1, 9'd0,   0, 1, 1, 0, 32'h0,        0, 1, 32'h00000013};
        vecs[9]  = '{1'b1, 32'hC,        1'b1, 9'd0,   1, 0, 1, 1, 32'h00300193, 0, 0, 32'h0};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 9'd300, 0, 1, 0, 0, 32'h0,        0, 1, 32'h0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 9'd0,   0, 0, 0, 0, 32'h0,        0, 0, 32'h0};

        // Requests held high during reset must not produce grants or strobes.
        rst_n = 1'b0; fetch_req = 1'b1; fetch_pc = 32'h0; ld_req = 1'b1; ld_we = 1'b1;
        ld_addr = '0; ld_wdata = 32'h0000FFFF; ld_done = 1'b0; ld_halt = 1'b0;
        #12;
        chk_reset_outputs("reset");
        fetch_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Program words 0..3 while fetch is also requesting.
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1'b1; fetch_pc = 32'h0;
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'(i); ld_wdata = words[i];
            #1;
            chk("load ld_gnt",    32'(ld_gnt),    32'd1);
            chk("load fetch_gnt", 32'(fetch_gnt), 32'd0);
            chk("load mem_we",    32'(mem_we),    32'd1);
            chk("load mem_addr",  32'(mem_addr),  32'(i));
            chk("load core_hold", 32'(core_hold), 32'd1);
            tick();
        end
        fetch_req = 1'b0;

        // Out-of-range write (index 256 aliases 0 in the low bits) must be dropped.
        ld_we = 1'b1; ld_addr = 9'd256; ld_wdata = 32'hDEADBEEF;
        #1;
        chk("oor wr ld_gnt", 32'(ld_gnt), 32'd1);
        chk("oor wr mem_en", 32'(mem_en), 32'd0);
        tick();
        ld_we = 1'b0; ld_addr = 9'd0;
        #1;
        chk("rd0 ld_gnt", 32'(ld_gnt), 32'd1);
        tick();
        chk("rd0 ld_rvalid", 32'(ld_rvalid), 32'd1);
        chk("rd0 ld_rdata",  ld_rdata,       32'h00000013);
        ld_addr = 9'd300;
        #1;
        chk("oor rd mem_en", 32'(mem_en), 32'd0);
        tick();
        chk("oor rd ld_rvalid", 32'(ld_rvalid), 32'd1);
        chk("oor rd ld_rdata",  ld_rdata,       32'd0);
        ld_req = 1'b0;

        // DONE with a simultaneous HALT in LOAD: DONE wins, hold drops next cycle.
        fetch_req = 1'b1; fetch_pc = 32'h0; ld_done = 1'b1; ld_halt = 1'b1;
        #1;
        chk("done core_hold",  32'(core_hold), 32'd1);
        chk("done fetch_gnt",  32'(fetch_gnt), 32'd0);
        fetch_req = 1'b0;
        tick();
        ld_done = 1'b0; ld_halt = 1'b0;
        chk("run core_hold", 32'(core_hold), 32'd0);

        for (int i = 0; i < 12; i++) begin
            fetch_req = vecs[i].fr; fetch_pc = vecs[i].pc;
            ld_req = vecs[i].lr; ld_we = 1'b0; ld_addr = vecs[i].la;
            #1;
            chk($sformatf("vec%0d fetch_gnt", i), 32'(fetch_gnt), 32'(vecs[i].e_fg));
            chk($sformatf("vec%0d ld_gnt", i),    32'(ld_gnt),    32'(vecs[i].e_lg));
            chk($sformatf("vec%0d mem_en", i),    32'(mem_en),    32'(vecs[i].e_me));
            tick();
            chk($sformatf("vec%0d fetch_valid", i), 32'(fetch_valid), 32'(vecs[i].e_fv));
            chk($sformatf("vec%0d fetch_inst", i),  fetch_inst,       vecs[i].e_fi);
            chk($sformatf("vec%0d fetch_err", i),   32'(fetch_err),   32'(vecs[i].e_fe));
            chk($sformatf("vec%0d ld_rvalid", i),   32'(ld_rvalid),   32'(vecs[i].e_lv));
            chk($sformatf("vec%0d ld_rdata", i),    ld_rdata,         vecs[i].e_ld);
        end

        // Starvation: forced loader slot in request cycles 9 and 18.
        fetch_req = 1'b1; fetch_pc = 32'h0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9'd1;
        for (int c = 1; c <= 18; c++) begin
            #1;
            chk($sformatf("starve c%0d ld_gnt", c),    32'(ld_gnt),    32'((c == 9) || (c == 18)));
            chk($sformatf("starve c%0d fetch_gnt", c), 32'(fetch_gnt), 32'(!((c == 9) || (c == 18))));
            tick();
        end
        fetch_req = 1'b0; ld_req = 1'b0;
        tick();

        // HALT alongside a granted fetch: response survives, next fetch blocked.
        fetch_req = 1'b1; fetch_pc = 32'h4; ld_halt = 1'b1;
        #1;
        chk("halt fetch_gnt", 32'(fetch_gnt), 32'd1);
        tick();
        ld_halt = 1'b0;
        chk("halt fetch_valid", 32'(fetch_valid), 32'd1);
        chk("halt fetch_inst",  fetch_inst,       32'h00100093);
        chk("halt core_hold",   32'(core_hold),   32'd1);
        #1;
        chk("halt next fetch_gnt", 32'(fetch_gnt), 32'd0);
        tick();
        chk("halt no valid", 32'(fetch_valid), 32'd0);
        fetch_req = 1'b0;
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        chk("rerun core_hold", 32'(core_hold), 32'd0);

        // Reset asserted one cycle after a fetch grant.
        fetch_req = 1'b1; fetch_pc = 32'h8;
        #1;
        chk("mid fetch_gnt", 32'(fetch_gnt), 32'd1);
        tick();
        fetch_req = 1'b0;
        chk("mid fetch_valid", 32'(fetch_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post fetch_valid", 32'(fetch_valid), 32'd0);
        chk("post core_hold",   32'(core_hold),   32'd1);
        tick();
        chk("post2 fetch_valid", 32'(fetch_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
